// File: rtl/debug_command_processor.sv
// ---------------------------------------------------------------------------
// debug_command_processor
//
// Decodes multi-byte debug frames from a UART receiver byte stream. It drives
// CPU halt/reset levels, performs debug register-file reads and writes, and
// returns response bytes to a UART transmitter over a ready/valid handshake.
//
// Frame format (opcode byte first):
//   0x00 NOP | 0x01 RESET | 0x02 UNRESET | 0x03 HALT | 0x04 UNHALT
//   0x05 PING        -> response 0xA5
//   0x06 READ_REG    + addr            -> response N data bytes, LSB first
//   0x07 WRITE_REG   + addr + N bytes  (data LSB first)
//   0x08 READ_CMD_COUNT (only with DEBUG_CMD_COUNTER_EN) -> 4 bytes, LSB first
//
// Optional feature macro: DEBUG_CMD_COUNTER_EN adds a 32-bit count of
// executed commands and the READ_CMD_COUNT opcode.
//
// Ports:
//   i_Clock, i_Reset_N          clock, asynchronous active-low reset
//   i_Rx_DV, i_Rx_Byte          received byte strobe and data
//   o_Tx_DV, o_Tx_Byte,
//   i_Tx_Ready                  response byte handshake
//   o_Halt_Cpu, o_Reset_Cpu     CPU control levels
//   o_Reg_Write_*               one-cycle register write strobe, addr, data
//   o_Reg_Read_*, i_Reg_Read_Data
//                               one-cycle read strobe, addr; data returns the
//                               cycle after the strobe
//   o_Overrun                   pulse: a byte arrived while busy and was lost
// ---------------------------------------------------------------------------
module debug_command_processor #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                      i_Clock,
    input  logic                      i_Reset_N,
    input  logic                      i_Rx_DV,
    input  logic [7:0]                i_Rx_Byte,
    output logic                      o_Tx_DV,
    output logic [7:0]                o_Tx_Byte,
    input  logic                      i_Tx_Ready,
    output logic                      o_Halt_Cpu,
    output logic                      o_Reset_Cpu,
    output logic                      o_Reg_Write_Enable,
    output logic [REG_ADDR_WIDTH-1:0] o_Reg_Write_Addr,
    output logic [DATA_WIDTH-1:0]     o_Reg_Write_Data,
    output logic                      o_Reg_Read_Enable,
    output logic [REG_ADDR_WIDTH-1:0] o_Reg_Read_Addr,
    input  logic [DATA_WIDTH-1:0]     i_Reg_Read_Data,
    output logic                      o_Overrun
);

    localparam int N_BYTES = DATA_WIDTH / 8;
`ifdef DEBUG_CMD_COUNTER_EN
    // The shift buffer must also hold the 32-bit command count.
    localparam int BUF_W = (DATA_WIDTH > 32) ? DATA_WIDTH : 32;
`else
    localparam int BUF_W = DATA_WIDTH;
`endif
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] OP_NOP       = 8'h00;
    localparam logic [7:0] OP_RESET     = 8'h01;
    localparam logic [7:0] OP_UNRESET   = 8'h02;
    localparam logic [7:0] OP_HALT      = 8'h03;
    localparam logic [7:0] OP_UNHALT    = 8'h04;
    localparam logic [7:0] OP_PING      = 8'h05;
    localparam logic [7:0] OP_READ_REG  = 8'h06;
    localparam logic [7:0] OP_WRITE_REG = 8'h07;
`ifdef DEBUG_CMD_COUNTER_EN
    localparam logic [7:0] OP_READ_CNT  = 8'h08;
`endif
    localparam logic [7:0] PING_REPLY   = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        EXECUTE,
        READ_WAIT,
        SEND
    } state_t;

    state_t                    state_q,   state_d;
    logic [7:0]                opcode_q,  opcode_d;
    logic [REG_ADDR_WIDTH-1:0] addr_q,    addr_d;
    logic [BUF_W-1:0]          buf_q,     buf_d;
    // GET_DATA: index of the next data byte. SEND: bytes still to transmit.
    logic [7:0]                byte_cnt_q, byte_cnt_d;
    logic [TMR_W-1:0]          timer_q,   timer_d;
    logic                      halt_q,    halt_d;
    logic                      rst_cpu_q, rst_cpu_d;
    logic                      wr_en_q,   wr_en_d;
    logic                      rd_en_q,   rd_en_d;
    logic                      overrun_q, overrun_d;
    // First SEND cycle after a read: the register port presents its data now.
    logic                      capture_q, capture_d;
`ifdef DEBUG_CMD_COUNTER_EN
    logic [31:0]               cmd_cnt_q, cmd_cnt_d;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case statement leaves a variable unassigned (no latch).
        state_d    = state_q;
        opcode_d   = opcode_q;
        addr_d     = addr_q;
        buf_d      = buf_q;
        byte_cnt_d = byte_cnt_q;
        timer_d    = timer_q;
        halt_d     = halt_q;
        rst_cpu_d  = rst_cpu_q;
        wr_en_d    = 1'b0;
        rd_en_d    = 1'b0;
        capture_d  = capture_q;
`ifdef DEBUG_CMD_COUNTER_EN
        cmd_cnt_d  = cmd_cnt_q;
`endif
        overrun_d  = i_Rx_DV &&
                     (state_q == EXECUTE || state_q == READ_WAIT || state_q == SEND);

        case (state_q)
            IDLE: begin
                if (i_Rx_DV) begin
                    opcode_d = i_Rx_Byte;
                    case (i_Rx_Byte)
                        OP_READ_REG, OP_WRITE_REG: begin
                            state_d = GET_ADDR;
                            timer_d = '0;
                        end
                        OP_NOP, OP_RESET, OP_UNRESET,
                        OP_HALT, OP_UNHALT, OP_PING:   state_d = EXECUTE;
`ifdef DEBUG_CMD_COUNTER_EN
                        OP_READ_CNT:                   state_d = EXECUTE;
`endif
                        default:                       state_d = IDLE;
                    endcase
                end
            end

            GET_ADDR: begin
                if (i_Rx_DV) begin
                    addr_d  = i_Rx_Byte[REG_ADDR_WIDTH-1:0];
                    timer_d = '0;
                    if (opcode_q == OP_READ_REG) begin
                        state_d = EXECUTE;
                    end else begin
                        state_d    = GET_DATA;
                        byte_cnt_d = '0;
                    end
                end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            GET_DATA: begin
                if (i_Rx_DV) begin
                    // Bytes enter at the top of the data word and move down, so
                    // after N bytes the first one received sits in bits [7:0].
                    buf_d                      = buf_q >> 8;
                    buf_d[DATA_WIDTH-1 -: 8]   = i_Rx_Byte;
                    timer_d                    = '0;
                    if (byte_cnt_q == 8'(N_BYTES - 1)) begin
                        state_d = EXECUTE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 8'd1;
                    end
                end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            EXECUTE: begin
                state_d = IDLE;
`ifdef DEBUG_CMD_COUNTER_EN
                cmd_cnt_d = cmd_cnt_q + 32'd1;
`endif
                case (opcode_q)
                    OP_RESET:     rst_cpu_d = 1'b1;
                    OP_UNRESET:   rst_cpu_d = 1'b0;
                    OP_HALT:      halt_d    = 1'b1;
                    OP_UNHALT:    halt_d    = 1'b0;
                    OP_WRITE_REG: wr_en_d   = 1'b1;
                    OP_PING: begin
                        buf_d      = BUF_W'(PING_REPLY);
                        byte_cnt_d = 8'd1;
                        state_d    = SEND;
                    end
                    OP_READ_REG: begin
                        rd_en_d = 1'b1;
                        state_d = READ_WAIT;
                    end
`ifdef DEBUG_CMD_COUNTER_EN
                    OP_READ_CNT: begin
                        // Pre-increment value: this frame is not counted.
                        buf_d      = BUF_W'(cmd_cnt_q);
                        byte_cnt_d = 8'd4;
                        state_d    = SEND;
                    end
`endif
                    default: ;
                endcase
            end

            // The read strobe is on the port during this cycle; the register
            // file answers one cycle later, so the capture happens in SEND.
            READ_WAIT: begin
                state_d    = SEND;
                capture_d  = 1'b1;
                byte_cnt_d = 8'(N_BYTES);
            end

            SEND: begin
                if (capture_q) begin
                    buf_d     = BUF_W'(i_Reg_Read_Data);
                    capture_d = 1'b0;
                end else if (i_Tx_Ready) begin
                    buf_d = buf_q >> 8;
                    if (byte_cnt_q == 8'd1) begin
                        state_d = IDLE;
                    end else begin
                        byte_cnt_d = byte_cnt_q - 8'd1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge i_Clock or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            state_q    <= IDLE;
            opcode_q   <= '0;
            addr_q     <= '0;
            buf_q      <= '0;
            byte_cnt_q <= '0;
            timer_q    <= '0;
            halt_q     <= 1'b0;
            rst_cpu_q  <= 1'b0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            overrun_q  <= 1'b0;
            capture_q  <= 1'b0;
`ifdef DEBUG_CMD_COUNTER_EN
            cmd_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            addr_q     <= addr_d;
            buf_q      <= buf_d;
            byte_cnt_q <= byte_cnt_d;
            timer_q    <= timer_d;
            halt_q     <= halt_d;
            rst_cpu_q  <= rst_cpu_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
            overrun_q  <= overrun_d;
            capture_q  <= capture_d;
`ifdef DEBUG_CMD_COUNTER_EN
            cmd_cnt_q  <= cmd_cnt_d;
`endif
        end
    end

    assign o_Tx_DV            = (state_q == SEND) && !capture_q;
    assign o_Tx_Byte          = buf_q[7:0];
    assign o_Halt_Cpu         = halt_q;
    assign o_Reset_Cpu        = rst_cpu_q;
    assign o_Reg_Write_Enable = wr_en_q;
    assign o_Reg_Write_Addr   = addr_q;
    assign o_Reg_Write_Data   = buf_q[DATA_WIDTH-1:0];
    assign o_Reg_Read_Enable  = rd_en_q;
    assign o_Reg_Read_Addr    = addr_q;
    assign o_Overrun          = overrun_q;

endmodule
